// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_reader: default widths, output buffer depth and FSM encoding.
package fifo_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned BUF_DEPTH  = 3;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side and downstream valid/ready signals of fifo_reader.
// m_parity exists only when FIFO_READER_PARITY_EN is defined.
interface fifo_reader_if import fifo_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
);

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_read;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  rd_count;
`ifdef FIFO_READER_PARITY_EN
    logic              m_parity;
`endif

    modport master (
        input  fifo_empty, fifo_data, m_ready,
`ifdef FIFO_READER_PARITY_EN
        output m_parity,
`endif
        output fifo_read, m_valid, m_data, rd_count
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
`ifdef FIFO_READER_PARITY_EN
        input  m_parity,
`endif
        input  fifo_read, m_valid, m_data, rd_count
    );

endinterface

// File: rtl/fifo_reader_buf.sv
// In-order output buffer of fifo_reader: shift register with head at entry 0.
module fifo_reader_buf import fifo_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [1:0]        occ_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_d [BUF_DEPTH];
    logic [1:0]        occ_q, occ_d;
    logic [1:0]        wr_idx;

    always_comb begin
        mem_d  = mem_q;
        occ_d  = occ_q;
        wr_idx = occ_q - 2'(pop_i);
        if (clear_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_d[i] = '0;
            occ_d = '0;
        end else begin
            // Vacated slots are zeroed so the head reads 0 whenever the buffer is empty.
            if (pop_i) begin
                for (int i = 0; i < BUF_DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
                mem_d[BUF_DEPTH-1] = '0;
            end
            if (push_i && (wr_idx < 2'(BUF_DEPTH))) mem_d[wr_idx] = wdata_i;
            occ_d = occ_q + 2'(push_i) - 2'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
            occ_q <= '0;
        end else begin
            mem_q <= mem_d;
            occ_q <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[0];

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops a same-clock FIFO (1-cycle read latency) into a 3-entry valid/ready buffer.
// Define FIFO_READER_PARITY_EN to add m_parity (even parity of m_data).
module fifo_reader import fifo_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          flush,
    fifo_reader_if.master bus
);

    state_e            state_q, state_d;
    logic              infl_q, infl_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [1:0]        occ;
    logic [DATA_W-1:0] head;
    logic [2:0]        sum_q, sum_nxt;
    logic              fifo_read, push, pop;

    assign sum_q = {1'b0, occ} + {2'b0, infl_q};

    // Read issue looks only at registered occupancy, never at m_ready.
    always_comb begin
        fifo_read  = reset && enable && !flush && !bus.fifo_empty && (sum_q < 3'(BUF_DEPTH));
        push       = infl_q && !flush;
        pop        = (occ != 2'd0) && bus.m_ready && !flush;
        infl_d     = fifo_read;
        rd_count_d = rd_count_q + CNT_W'(pop);
        sum_nxt    = flush ? 3'd0
                           : {1'b0, occ} + 3'(push) - 3'(pop) + 3'(infl_d);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable && !bus.fifo_empty) state_d = StRun;
            StRun:   if (sum_nxt == 3'(BUF_DEPTH)) state_d = StStall;
            StStall: if (pop) state_d = StRun;
            default: state_d = StIdle;
        endcase
        if (flush || (sum_nxt == 3'd0 && (!enable || bus.fifo_empty))) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            infl_q     <= 1'b0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            infl_q     <= infl_d;
            rd_count_q <= rd_count_d;
        end
    end

    fifo_reader_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.fifo_data),
        .occ_o   (occ),
        .head_o  (head)
    );

    assign bus.fifo_read = fifo_read;
    assign bus.m_valid   = (occ != 2'd0);
    assign bus.m_data    = head;
    assign bus.rd_count  = rd_count_q;
`ifdef FIFO_READER_PARITY_EN
    assign bus.m_parity  = ^head;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: queue-based FIFO/buffer model plus directed scenarios.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 8;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
    logic flush  = 1'b0;

    fifo_reader_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    fifo_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] mdl_buf[$];
    logic [DW-1:0] deliv_q[$];
    bit          mdl_infl;
    logic [DW-1:0] mdl_pend;
    int unsigned mdl_cnt;
    int          reads_seen;
    bit          last_valid, last_read, last_par;
    logic [DW-1:0] last_data;
    logic [CW-1:0] last_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_src(input logic [DW-1:0] w);
        src_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance model, then update the FIFO source.
    task automatic tick();
        bit read_now;
        bit exp_read;
        @(negedge clk);
        read_now   = bus.fifo_read;
        last_read  = bus.fifo_read;
        last_valid = bus.m_valid;
        last_data  = bus.m_data;
        last_cnt   = bus.rd_count;
`ifdef FIFO_READER_PARITY_EN
        last_par   = bus.m_parity;
`endif
        if (bus.fifo_read) reads_seen++;
        if (!reset) begin
            chk("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
            chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
            chk("rst_m_data", 32'(bus.m_data), 32'd0);
            chk("rst_rd_count", 32'(bus.rd_count), 32'd0);
            mdl_buf.delete();
            mdl_infl = 1'b0;
            mdl_cnt  = 0;
        end else begin
            exp_read = enable && !flush && (src_q.size() > 0)
                       && (mdl_buf.size() + int'(mdl_infl) < 3);
            chk("fifo_read", 32'(bus.fifo_read), 32'(exp_read));
            chk("m_valid", 32'(bus.m_valid), 32'(mdl_buf.size() > 0));
            if (mdl_buf.size() > 0) chk("m_data", 32'(bus.m_data), 32'(mdl_buf[0]));
            chk("rd_count", 32'(bus.rd_count), 32'(mdl_cnt % (1 << CW)));
`ifdef FIFO_READER_PARITY_EN
            if (mdl_buf.size() > 0) chk("m_parity", 32'(bus.m_parity), 32'(^mdl_buf[0]));
`endif
            if (bus.m_valid && bus.m_ready && !flush) deliv_q.push_back(bus.m_data);
            if (flush) begin
                mdl_buf.delete();
                mdl_infl = 1'b0;
            end else begin
                if (mdl_buf.size() > 0 && bus.m_ready) begin
                    void'(mdl_buf.pop_front());
                    mdl_cnt++;
                end
                if (mdl_infl) mdl_buf.push_back(mdl_pend);
                mdl_infl = exp_read;
                if (exp_read) mdl_pend = src_q[0];
            end
        end
        @(posedge clk);
        #1;
        if (read_now && src_q.size() > 0) bus.fifo_data = src_q.pop_front();
        else bus.fifo_data = DW'($urandom);
        bus.fifo_empty = (src_q.size() == 0);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        enable      = 1'b0;
        flush       = 1'b0;
        bus.m_ready = 1'b0;
        src_q.delete();
        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        tick();
        tick();
        reset = 1'b1;
        deliv_q.delete();
        reads_seen = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_v [7];
        int exp_d [7];
        int guard;
        bit saw255;

        // Basic stream 1,2,3,5: first word two cycles after first read
        exp_v = '{0, 0, 1, 1, 1, 1, 0};
        exp_d = '{0, 0, 1, 2, 3, 5, 0};
        do_reset();
        push_src(4'd1); push_src(4'd2); push_src(4'd3); push_src(4'd5);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("stream_valid", 32'(last_valid), 32'(exp_v[k]));
            if (exp_v[k] != 0) chk("stream_data", 32'(last_data), 32'(exp_d[k]));
        end
        chk("stream_count", 32'(last_cnt), 32'd4);

        // Backpressure: three reads fill the buffer, head held
        do_reset();
        for (int i = 1; i <= 8; i++) push_src(DW'(i));
        enable = 1'b1;
        repeat (6) tick();
        chk("bp_reads", 32'(reads_seen), 32'd3);
        chk("bp_valid", 32'(last_valid), 32'd1);
        chk("bp_head", 32'(last_data), 32'd1);
        bus.m_ready = 1'b1;
        guard = 0;
        while (deliv_q.size() < 8 && guard < 40) begin tick(); guard++; end
        chk("bp_total", 32'(deliv_q.size()), 32'd8);
        for (int i = 0; i < deliv_q.size(); i++) chk("bp_order", 32'(deliv_q[i]), 32'(i + 1));

        // FIFO runs dry after 6,7 then refilled with 8
        do_reset();
        push_src(4'd6); push_src(4'd7);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (6) tick();
        chk("dry_count", 32'(deliv_q.size()), 32'd2);
        if (deliv_q.size() == 2) begin
            chk("dry_w0", 32'(deliv_q[0]), 32'd6);
            chk("dry_w1", 32'(deliv_q[1]), 32'd7);
        end
        chk("dry_valid", 32'(last_valid), 32'd0);
        chk("dry_read", 32'(last_read), 32'd0);
        chk("dry_state", 32'(dut.state_q), 32'(StIdle));
        push_src(4'd8);
        repeat (4) tick();
        chk("refill_count", 32'(deliv_q.size()), 32'd3);
        if (deliv_q.size() == 3) chk("refill_word", 32'(deliv_q[2]), 32'd8);

        // Asynchronous reset after the third word
        do_reset();
        for (int i = 1; i <= 8; i++) push_src(DW'(i));
        enable = 1'b1;
        bus.m_ready = 1'b1;
        guard = 0;
        while (deliv_q.size() < 3 && guard < 20) begin tick(); guard++; end
        reset = 1'b0;
        #1;
        chk("arst_fifo_read", 32'(bus.fifo_read), 32'd0);
        chk("arst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("arst_m_data", 32'(bus.m_data), 32'd0);
        chk("arst_rd_count", 32'(bus.rd_count), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        deliv_q.delete();
        guard = 0;
        while (deliv_q.size() < 1 && guard < 20) begin tick(); guard++; end
        chk("arst_next_count", 32'(deliv_q.size()), 32'd1);
        if (deliv_q.size() > 0) chk("arst_next_word", 32'(deliv_q[0]), 32'd6);
        tick();
        chk("arst_restart_cnt", 32'(last_cnt), 32'd1);

        // Flush with two buffered and one in flight
        do_reset();
        for (int i = 1; i <= 8; i++) push_src(DW'(i));
        enable = 1'b1;
        repeat (3) tick();
        flush = 1'b1;
        tick();
        chk("flush_read", 32'(last_read), 32'd0);
        flush = 1'b0;
        tick();
        chk("flush_valid", 32'(last_valid), 32'd0);
        chk("flush_cnt", 32'(last_cnt), 32'd0);
        bus.m_ready = 1'b1;
        guard = 0;
        while (deliv_q.size() < 1 && guard < 20) begin tick(); guard++; end
        chk("flush_next_count", 32'(deliv_q.size()), 32'd1);
        if (deliv_q.size() > 0) chk("flush_next_word", 32'(deliv_q[0]), 32'd4);

`ifdef FIFO_READER_PARITY_EN
        do_reset();
        push_src(4'd7); push_src(4'd5);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (6) begin
            tick();
            if (last_valid && last_data == 4'd7) chk("parity_7", 32'(last_par), 32'd1);
            if (last_valid && last_data == 4'd5) chk("parity_5", 32'(last_par), 32'd0);
        end
`endif

        // Counter wrap after 256 transfers
        do_reset();
        for (int i = 0; i < 256; i++) push_src(DW'($urandom));
        enable = 1'b1;
        bus.m_ready = 1'b1;
        saw255 = 1'b0;
        guard = 0;
        while (deliv_q.size() < 256 && guard < 400) begin
            tick();
            if (last_cnt == 8'd255) saw255 = 1'b1;
            guard++;
        end
        tick();
        chk("wrap_saw255", 32'(saw255), 32'd1);
        chk("wrap_zero", 32'(last_cnt), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            enable      = ($urandom_range(0, 9) < 8);
            bus.m_ready = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 29) == 0);
            if (src_q.size() < 3 && $urandom_range(0, 3) == 0) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) push_src(DW'($urandom));
            end
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 4, data word width.
REQ-002 SHALL have parameter CNT_W, default 8, width of delivered-word counter.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  permits issuing new FIFO reads.
REQ-006 SHALL have port flush  input  1  synchronous discard of buffered and in-flight words.
REQ-007 SHALL have port fifo_empty  input  1  FIFO empty flag, same clock domain.
REQ-008 SHALL have port fifo_data  input  DATA_W  FIFO read data, valid one cycle after fifo_read.
REQ-009 SHALL have port fifo_read  output  1  one-cycle pop request per word.
REQ-010 SHALL have port m_valid  output  1  downstream word available.
REQ-011 SHALL have port m_ready  input  1  downstream accepts word.
REQ-012 SHALL have port m_data  output  DATA_W  downstream word.
REQ-013 SHALL have port rd_count  output  CNT_W  count of words accepted downstream.

Function
REQ-014 SHALL hold a 3-entry in-order output buffer; occ = entries held, infl = reads issued but not yet captured (0 or 1).
REQ-015 SHALL assert fifo_read in a cycle iff enable=1, flush=0, fifo_empty=0, and occ+infl<3; combinational from registered occ/infl only, never from m_ready.
REQ-016 SHALL capture fifo_data at the end of the cycle following fifo_read; earliest m_valid is read cycle N+2.
REQ-017 SHALL sustain one word per cycle when fifo_empty=0 and m_ready=1 continuously.
REQ-018 SHALL drive m_valid=1 iff occ>0; m_data SHALL equal the oldest entry.
REQ-019 SHALL hold m_valid and m_data stable while m_valid=1 and m_ready=0.
REQ-020 SHALL transfer a word on m_valid&m_ready; capture and transfer in the same cycle SHALL leave occ unchanged.
REQ-021 SHALL increment rd_count by 1 per transfer, wrapping 2^CNT_W-1 -> 0.
REQ-022 SHALL implement states IDLE (enable=0 or empty, occ=infl=0), RUN (reads permitted), STALL (occ+infl=3); IDLE->RUN on enable&!fifo_empty; RUN->STALL when occ+infl reaches 3; STALL->RUN on a transfer; any->IDLE when enable=0 and occ=infl=0.
REQ-023 SHALL, on enable deassert, issue no new reads but still deliver buffered and in-flight words.
REQ-024 SHALL, on flush=1, clear occ and infl, drop the word returning next cycle, deassert fifo_read, leave rd_count unchanged, and enter IDLE.
REQ-025 SHALL ignore fifo_data in cycles without a pending read.

Reset
REQ-026 SHALL, while reset=0, force fifo_read=0, m_valid=0, m_data=0, rd_count=0, occ=infl=0, state IDLE, regardless of clk.
REQ-027 SHALL discard any in-flight word when reset asserts mid-operation; first read permitted on the first edge after reset=1.

Configuration
REQ-028 SHALL, with FIFO_READER_PARITY_EN defined, add output m_parity (1 bit) = XOR of m_data bits (even parity), stable with m_data.
REQ-029 SHALL, without FIFO_READER_PARITY_EN, omit m_parity and its logic entirely.

Structure
REQ-030 SHALL place DATA_W/CNT_W defaults and the state encoding (IDLE, RUN, STALL) in shared package fifo_pkg.
REQ-031 SHALL implement the 3-entry buffer as sub-module fifo_reader_buf (push, pop, occ, head outputs).

Verification
REQ-032 FIFO preloaded 1,2,3,5, enable=1, m_ready=1 -> m_data 1,2,3,5 on consecutive cycles, first at read+2, rd_count=4.
REQ-033 Preload 1..8, m_ready=0 -> exactly 3 reads issued, m_valid=1, m_data=1 held; release m_ready -> 1..8 in order, no loss.
REQ-034 fifo_empty goes 1 after two words 6,7 -> fifo_read stops, m_valid drops after 7, state IDLE; refill with 8 -> delivered.
REQ-035 reset=0 mid-stream after word 3 of 1..8 -> all outputs 0 immediately; after release, next delivered is FIFO's next word, rd_count restarts at 0.
REQ-036 flush=1 with occ=2, infl=1 -> m_valid=0 next cycle, returning word dropped, rd_count unchanged.
REQ-037 With FIFO_READER_PARITY_EN, m_data=7 -> m_parity=1, m_data=5 -> m_parity=0; rd_count wraps 255->0 after 256 transfers.
